// File: rtl/tick_sample_buffer.sv
// Tick-strobed sample capture into a first-word-fall-through FIFO feeding the FIR stage.
// A small IDLE/RUN/DRAIN FSM gates capture. Overflow and the drop counter are sticky until cleared.
module tick_sample_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       tick,
  input  logic [DATA_W-1:0]          in_data,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_overflow;
  logic [7:0]          r_drop_cnt;

  logic                w_capture;
  logic                w_pop;
  logic                w_full;
  logic                w_write;
  logic                w_drop;
  logic [LVL_W-1:0]    w_level_next;

  assign w_capture    = (r_state == ST_RUN) && tick;
  assign w_pop        = out_valid && out_ready;
  assign w_full       = (r_level == LVL_W'(DEPTH));
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign w_write      = w_capture && (!w_full || w_pop);
  assign w_drop       = w_capture && w_full && !w_pop;
  assign w_level_next = r_level + LVL_W'(w_write) - LVL_W'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      case (r_state)
        ST_IDLE:  if (en) r_state <= ST_RUN;
        ST_RUN:   if (!en) r_state <= (w_level_next != '0) ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: begin
          if (en)                         r_state <= ST_RUN;
          else if (w_level_next == '0)    r_state <= ST_IDLE;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by r_level, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf)                 r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign level     = r_level;
  assign busy      = (r_state != ST_IDLE);
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_tick_sample_buffer.sv
// Directed bench for tick_sample_buffer (DATA_W=16, DEPTH=8) with hand-computed expectations.
// Inputs change 1ns after the rising edge and outputs are sampled in the same window.
module tb_tick_sample_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic              en;
  logic              tick;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        level;
  logic              busy;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              clr_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  tick_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tick      (tick),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .busy      (busy),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_q [$];

  initial begin
    rst = 1'b1; en = 1'b0; tick = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    #2;
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_dcnt", drop_cnt, 0);
    check("rst_data", out_data, 0);
    step();
    rst = 1'b0;
    step();

    // Ticks in IDLE are ignored; en plus tick in IDLE only moves to RUN.
    tick = 1'b1; in_data = 16'h55;
    step();
    check("idle_tick_level", level, 0);
    en = 1'b1;
    step();
    check("first_en_level", level, 0);
    check("first_en_busy", busy, 1);
    check("first_en_ovf", overflow, 0);
    tick = 1'b0;

    // Streaming: one-cycle latency, level never above 1.
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick = 1'b1; in_data = 16'(k);
      step();
      tick = 1'b0;
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, k);
      check("stream_level", level, 1);
      step();
      check("stream_pop_valid", out_valid, 0);
      check("stream_pop_level", level, 0);
      step(); step();
    end

    // Overfill: 10 ticks, 8 stored, 2 dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick = 1'b1; in_data = 16'(k);
      step();
    end
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_dcnt", drop_cnt, 2);
    check("ovf_head", out_data, 0);

    // Full FIFO, tick with pop: no drop, new sample goes last.
    in_data = 16'd100; out_ready = 1'b1;
    step();
    tick = 1'b0;
    check("full_pop_level", level, 8);
    check("full_pop_dcnt", drop_cnt, 2);
    check("full_pop_head", out_data, 1);
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd100};
    foreach (exp_q[i]) begin
      check("drain_order", out_data, exp_q[i]);
      step();
    end
    check("drain_level", level, 0);
    check("drain_valid", out_valid, 0);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_dcnt", drop_cnt, 0);

    // en falls with 3 stored: DRAIN ignores ticks and empties into IDLE.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1; in_data = 16'hA1 + 16'(k);
      step();
    end
    tick = 1'b0; en = 1'b0;
    step();
    check("drain_busy", busy, 1);
    check("drain_lvl3", level, 3);
    tick = 1'b1; in_data = 16'hEE;
    step();
    tick = 1'b0;
    check("drain_tick_level", level, 3);
    check("drain_tick_dcnt", drop_cnt, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("drain_data", out_data, 16'hA1 + 16'(k));
      step();
    end
    check("drain_idle_busy", busy, 0);
    check("drain_idle_level", level, 0);

    // Drop coinciding with clr_ovf, then saturation.
    en = 1'b1; out_ready = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      tick = 1'b1; in_data = 16'(k + 16'h200);
      step();
    end
    clr_ovf = 1'b1;
    step();
    check("clr_drop_ovf", overflow, 1);
    check("clr_drop_dcnt", drop_cnt, 1);
    tick = 1'b0;
    step();
    clr_ovf = 1'b0;
    check("clr_only_dcnt", drop_cnt, 0);
    tick = 1'b1;
    for (int k = 0; k < 300; k++) step();
    tick = 1'b0;
    check("sat_dcnt", drop_cnt, 255);
    check("sat_ovf", overflow, 1);

    // Async reset between edges with 5 stored.
    out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    check("pre_rst_level", level, 5);
    #3 rst = 1'b1;
    #1;
    check("async_level", level, 0);
    check("async_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_ovf", overflow, 0);
    check("async_dcnt", drop_cnt, 0);
    check("async_data", out_data, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 1);
    step();
    check("post_rst_level", level, 0);
    check("post_rst_valid2", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_sample_buffer.md
TICK_SAMPLE_BUFFER -- requirements
Module: tick_sample_buffer

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, at least 2.
REQ-003 clk  in  1: sole clock; all state updates on rising edge.
REQ-004 rst  in  1: asynchronous, active-high reset.
REQ-005 en  in  1: capture enable; level-sensitive.
REQ-006 tick  in  1: one-cycle sample strobe from the clock divider stage.
REQ-007 in_data  in  DATA_W: sample source; sampled only in a capture cycle.
REQ-008 out_data  out  DATA_W: head-of-FIFO sample to the FIR filter.
REQ-009 out_valid  out  1: out_data holds a valid sample.
REQ-010 out_ready  in  1: FIR filter accepts out_data.
REQ-011 level  out  $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
REQ-012 busy  out  1: high whenever the FSM is not in IDLE.
REQ-013 overflow  out  1: sticky flag; a sample was dropped.
REQ-014 drop_cnt  out  8: count of dropped samples; saturates at 255.
REQ-015 clr_ovf  in  1: one-cycle pulse that clears overflow and drop_cnt.

Function
REQ-016 FSM states are IDLE, RUN and DRAIN.
REQ-017 IDLE goes to RUN on the next edge when en=1.
REQ-018 RUN goes to DRAIN when en=0 and post-edge level>0; it goes to IDLE when en=0 and post-edge level=0.
REQ-019 DRAIN goes to RUN when en=1; it goes to IDLE when en=0 and post-edge level=0.
REQ-020 Capture cycle: state=RUN and tick=1; ticks in IDLE or DRAIN are ignored with no count, no drop and no flag.
REQ-021 Pop cycle: out_valid=1 and out_ready=1; head advances on that edge.
REQ-022 A capture writes in_data at the tail when level<DEPTH, or when level=DEPTH with a same-cycle pop.
REQ-023 A capture with level=DEPTH and no same-cycle pop drops the sample.
REQ-024 A dropped sample sets overflow and increments drop_cnt, saturating at 255.
REQ-025 FIFO is first-word-fall-through: out_valid = (level>0), and out_data = head entry, driven from a registered or memory-read path without combinational dependence on out_ready.
REQ-026 Latency: a capture at edge N into an empty FIFO gives out_valid=1 and out_data=sample after edge N.
REQ-027 Simultaneous capture and pop leaves level unchanged and keeps order strict FIFO.
REQ-028 Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-029 level changes by +1, -1 or 0 per cycle and never exceeds DEPTH.
REQ-030 out_data is don't-care when out_valid=0.
REQ-031 A pop with out_valid=0 is a no-op.
REQ-032 clr_ovf clears overflow and drop_cnt on the next edge.
REQ-033 When clr_ovf coincides with a drop, the result is overflow=1 and drop_cnt=1.
REQ-034 An en change mid-stream never discards stored samples; DRAIN delivers all of them.

Reset
REQ-035 While rst=1, regardless of clk: state=IDLE, pointers=0, level=0, out_valid=0, busy=0, overflow=0, drop_cnt=0.
REQ-036 out_data resets to 0.
REQ-037 Reset asserted mid-operation discards all stored samples immediately.
REQ-038 After reset deassertion, the first capture requires en=1 for one edge (IDLE to RUN) before a tick is honoured.

Verification
REQ-039 Scenario: en=1, out_ready=1, ticks every 4 cycles with in_data 1,2,3 -> out_valid pulses with out_data 1,2,3, each one cycle after its tick, level never exceeds 1.
REQ-040 Scenario: out_ready=0, DEPTH=8, 10 ticks with data 0..9 -> level=8, data 0..7 held, overflow=1, drop_cnt=2; then out_ready=1 -> drains 0..7 in order.
REQ-041 Scenario: FIFO full, tick coincides with pop -> no drop, level stays 8, new sample appears last.
REQ-042 Scenario: 3 samples stored, en drops to 0 with out_ready=0 -> busy=1 in DRAIN; a tick has no effect; out_ready=1 -> 3 pops, then IDLE, busy=0.
REQ-043 Scenario: drop and clr_ovf in the same cycle -> overflow=1, drop_cnt=1; 300 drops -> drop_cnt=255.
REQ-044 Scenario: rst pulsed asynchronously between edges with level=5 -> outputs reach reset values before the next edge; no stale sample is delivered afterwards.
